// File: rtl/frame_addr_pkg.sv
// Shared constants for the ping-pong frame buffer address generator.
// Holds bank width, per-port reset banks and the default frame geometry.
// Imported by frame_port_cnt and frame_addr_gen.
package frame_addr_pkg;

  localparam int BANK_W = 2;

  // Write and read start on opposite banks so they never collide out of reset.
  localparam logic [BANK_W-1:0] WR_BANK_RST = 2'b00;
  localparam logic [BANK_W-1:0] RD_BANK_RST = 2'b11;

  // 640x480 frame, 256-word SDRAM bursts, 4M-word bank.
  localparam int ADDR_W_DEF      = 22;
  localparam int FRAME_WORDS_DEF = 307200;
  localparam int BURST_LEN_DEF   = 256;

endpackage

// File: rtl/frame_port_cnt.sv
// Burst address counter for one SDRAM port: bank latch, word address, sticky done.
// Latency: address/bank/done update on the edge after load or burst_done.
// Backpressure: none; pulses are consumed every cycle, load beats burst_done.
// Ports: clk, rst_n (async active-low); bank/load select a new frame;
//        burst_done advances the address; addr = {bank, word}; done = frame complete.
module frame_port_cnt
  import frame_addr_pkg::*;
#(
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int               BURST_LEN   = BURST_LEN_DEF,
  parameter logic [BANK_W-1:0] RST_BANK   = WR_BANK_RST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BANK_W-1:0]        bank,
  input  logic                     load,
  input  logic                     burst_done,
  output logic [BANK_W+ADDR_W-1:0] addr,
  output logic                     done
);

  // One extra bit so a + BURST_LEN cannot overflow when a is near the top
  // of a full 2**ADDR_W bank.
  localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FRAME_WORDS);

  logic [ADDR_W-1:0] word;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W:0]   word_next;

  assign word_next = {1'b0, word} + STEP;
  assign addr      = {bank_q, word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word   <= '0;
      bank_q <= RST_BANK;
      done   <= 1'b0;
    end else if (load) begin
      // A burst completing in the same cycle belongs to the old frame.
      word   <= '0;
      bank_q <= bank;
      done   <= 1'b0;
    end else if (burst_done) begin
      if (word_next < LIMIT) begin
        word <= word_next[ADDR_W-1:0];
      end else begin
        // Wrap: keep streaming the same bank until the next load.
        word <= '0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_addr_gen.sv
// Burst address and frame-status generator for the SDRAM ping-pong frame buffer.
// Latency: addresses 1 cycle after load/burst_done; bank_valid 1 cycle after done.
// Backpressure: none; every load and burst_done pulse is acted on immediately.
// Ports: clk, rst_n (async active-low); wr_/rd_ bank+load from the switch
//        controller; wr_/rd_burst_done from the SDRAM controller; wr_/rd_addr
//        burst addresses; frame_write_done/frame_read_done sticky; bank_valid.
// Build option: define BANK_VALID_RD_GATE_EN to hold bank_valid until the
//               read side has also finished its frame.
module frame_addr_gen
  import frame_addr_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic                     wr_load,
  input  logic [BANK_W-1:0]        rd_bank,
  input  logic                     rd_load,
  input  logic                     wr_burst_done,
  input  logic                     rd_burst_done,
  output logic [BANK_W+ADDR_W-1:0] wr_addr,
  output logic [BANK_W+ADDR_W-1:0] rd_addr,
  output logic                     frame_write_done,
  output logic                     frame_read_done,
  output logic                     bank_valid
);

  logic swap_ready;

  frame_port_cnt #(
    .ADDR_W     (ADDR_W),
    .FRAME_WORDS(FRAME_WORDS),
    .BURST_LEN  (BURST_LEN),
    .RST_BANK   (WR_BANK_RST)
  ) u_wr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank      (wr_bank),
    .load      (wr_load),
    .burst_done(wr_burst_done),
    .addr      (wr_addr),
    .done      (frame_write_done)
  );

  frame_port_cnt #(
    .ADDR_W     (ADDR_W),
    .FRAME_WORDS(FRAME_WORDS),
    .BURST_LEN  (BURST_LEN),
    .RST_BANK   (RD_BANK_RST)
  ) u_rd_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank      (rd_bank),
    .load      (rd_load),
    .burst_done(rd_burst_done),
    .addr      (rd_addr),
    .done      (frame_read_done)
  );

`ifdef BANK_VALID_RD_GATE_EN
  // Swap only once the display has consumed a whole frame as well.
  assign swap_ready = frame_write_done & frame_read_done;
`else
  assign swap_ready = frame_write_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_valid <= 1'b0;
    end else begin
      bank_valid <= swap_ready;
    end
  end

endmodule

// File: doc/frame_addr_gen.md
# frame_addr_gen

Address and frame-status generator for the SDRAM ping-pong frame buffer. It consumes the bank selects and load pulses from the bank-switch controller and produces the per-port burst addresses for the SDRAM FIFO controller. It tracks burst completions on the camera write port and the display read port. It returns the frame-complete status (`frame_write_done`, `frame_read_done`, `bank_valid`) that closes the bank-switch handshake.

## Interface
- `ADDR_W`, 22: word address width within one bank.
- `FRAME_WORDS`, 307200: words per frame (640x480); must be a multiple of `BURST_LEN` and ≤ 2**ADDR_W.
- `BURST_LEN`, 256: words per SDRAM burst; address step per completed burst.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_bank` in 2: write bank select from the switch controller.
- `wr_load` in 1: one-cycle pulse that starts a new write frame.
- `rd_bank` in 2: read bank select.
- `rd_load` in 1: one-cycle pulse that starts a new read frame.
- `wr_burst_done` in 1: one-cycle pulse from the SDRAM controller when a write burst has completed.
- `rd_burst_done` in 1: one-cycle pulse when a read burst has completed.
- `wr_addr` out 2+ADDR_W: `{latched wr bank, word address}` for the next write burst.
- `rd_addr` out 2+ADDR_W: `{latched rd bank, word address}` for the next read burst.
- `frame_write_done` out 1: sticky; the write frame has been fully written.
- `frame_read_done` out 1: sticky; the read frame has been fully read.
- `bank_valid` out 1: registered frame-ready indication; its rising edge requests a bank swap.

## Operation
- Two identical port counters: write and read. Each has a word address `a`, a latched bank `b` and a sticky `done`.
- Load cycle (`*_load`=1):
  - `a` ← 0
  - `b` ← `*_bank` input
  - `done` ← 0
- Burst-done cycle with no load:
  - If `a + BURST_LEN < FRAME_WORDS`: `a` ← `a + BURST_LEN`.
  - Otherwise: `a` ← 0 (wrap) and `done` ← 1.
  - Comparison is computed at ADDR_W+1 bits so it cannot overflow.
- Wrap without a new load: the port keeps streaming into the same bank, overwriting (write) or re-reading (read). `done` stays 1.
- Load and burst_done in the same cycle: load wins and the burst is discarded. Result is `a`=0, `done`=0.
- `bank_valid` is registered from the `done` flags. It deasserts the cycle after the gating `done` clears.
- Bank inputs are sampled only on load. A change of `*_bank` between loads does not affect the outputs.

## Timing
- Reset values:
  - `wr_addr` = {2'b00, 0}
  - `rd_addr` = {2'b11, 0}
  - `frame_write_done` = 0, `frame_read_done` = 0
  - `bank_valid` = 0
- Latencies:
  - Address update, 1 cycle after burst_done or load.
  - `done` set, same edge as the wrap.
  - `bank_valid`, 1 cycle after its gating `done` condition becomes true.
- `done` is a level held until the next load, so the switch controller can sample it in any later cycle.
- Reset asserted mid-frame returns all outputs to their reset values immediately.
- The first `burst_done` after reset is counted as normal; no load is required.

## Configuration
- `BANK_VALID_RD_GATE_EN` defined: `bank_valid` ← `frame_write_done & frame_read_done`. The swap waits until the display has finished a full frame.
- `BANK_VALID_RD_GATE_EN` undefined: `bank_valid` ← `frame_write_done` only. The read side never delays the swap request.

## Structure
- Package `frame_addr_pkg` holds:
  - `BANK_W` = 2
  - reset bank constants `WR_BANK_RST` = 2'b00 and `RD_BANK_RST` = 2'b11
  - default `FRAME_WORDS`, `BURST_LEN` and `ADDR_W`.
- Sub-module `frame_port_cnt` contains the address, bank latch and sticky done for one port. It takes a reset-bank parameter and is instantiated twice, once per port.
- The top level holds only the `bank_valid` register and the macro gate.

## Test plan
All scenarios use `FRAME_WORDS`=1024, `BURST_LEN`=256, `ADDR_W`=10.
- Reset, then 3 `wr_burst_done` pulses:
  - `wr_addr` = 0x000, 0x100, 0x200, 0x300
  - `frame_write_done` stays 0.
- 4th `wr_burst_done`:
  - `wr_addr` wraps to 0x000.
  - `frame_write_done`=1 on the same edge.
  - `bank_valid`=1 one cycle later (macro undefined).
- `wr_bank`=2'b11 with `wr_load` pulse:
  - `wr_addr`={2'b11, 0x000}
  - `frame_write_done`=0
  - `bank_valid`=0 one cycle later.
- `wr_load` and `wr_burst_done` in the same cycle at `a`=0x200: `wr_addr`=0x000 and `done`=0.
- Macro defined, write completes while read is at 0x100:
  - `bank_valid` stays 0.
  - After 3 more `rd_burst_done` pulses, `frame_read_done`=1 and `bank_valid`=1 one cycle later.
- `rst_n` low mid-frame (`rd_addr`=0x200, both `done` flags set): all outputs return to their reset values asynchronously.
